// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N:1 valid/ready selector with a registered output stage; explicit select (MODE 0)
// or round-robin arbitration (MODE 1). Define PIPE_MUX_N_SKID_EN to add a one-entry skid register.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] chosen_idx;
  logic             chosen_vld;
  logic [WIDTH-1:0] chosen_data;
  logic             load;
  logic             xfer;
  int unsigned      scan_best;
  int unsigned      scan_dist;

`ifdef PIPE_MUX_N_SKID_EN
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_src_q, skid_src_d;
  logic             skid_full_q, skid_full_d;

  // Reset gates load so no input is accepted while reset is held.
  assign load = !reset && !flush && !skid_full_q;
`else
  assign load = !reset && !flush && (!out_valid_q || out_ready);
`endif

  // Round-robin: pick the valid channel with the smallest distance past the pointer.
  always_comb begin
    chosen_vld = 1'b0;
    chosen_idx = '0;
    scan_best  = NUM_IN;
    scan_dist  = 0;
    if (MODE == 0) begin
      chosen_vld = int'(sel) < NUM_IN;
      chosen_idx = sel;
    end else begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (i > 32'(ptr_q)) scan_dist = i - 32'(ptr_q) - 1;
        else                scan_dist = i + NUM_IN - 32'(ptr_q) - 1;
        if (in_valid[i] && scan_dist < scan_best) begin
          scan_best  = scan_dist;
          chosen_idx = SEL_W'(i);
          chosen_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready    = '0;
    chosen_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = load && chosen_vld && (32'(chosen_idx) == i) && (MODE == 0 || in_valid[i]);
      if (32'(chosen_idx) == i) chosen_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign xfer  = |(in_ready & in_valid);
  assign ptr_d = xfer ? chosen_idx : ptr_q;

`ifdef PIPE_MUX_N_SKID_EN
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // A held skid entry is older than anything arriving now, so it drains first.
      if (skid_full_q) begin
        out_data_d  = skid_data_q;
        out_src_d   = skid_src_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (xfer) begin
        out_data_d  = chosen_data;
        out_src_d   = chosen_idx;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (xfer) begin
      skid_data_d = chosen_data;
      skid_src_d  = chosen_idx;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data_q <= '0;
      skid_src_q  <= '0;
      skid_full_q <= 1'b0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      skid_full_q <= skid_full_d;
    end
  end
`else
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_data_d  = chosen_data;
      out_src_d   = chosen_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(NUM_IN - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
Parametrised N:1 selector with a registered output stage and valid/ready handshakes on every input and on the output. It generalises the fixed 2/3/4-way datapath muxes to any input count. Two modes: explicit select, or round-robin arbitration among valid inputs. It sits between pipeline stages wherever several producers share one consumer, for example writeback or result-bus merging.

Parameters:
WIDTH, 32, data width per channel
NUM_IN, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must satisfy 2**SEL_W >= NUM_IN
MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-channel valid
in_ready  output  NUM_IN  per-channel ready; at most one bit high per cycle
sel  input  SEL_W  channel index, used in MODE 0 only
flush  input  1  synchronous flush of the output stage
out_data  output  WIDTH  registered selected data
out_src  output  SEL_W  registered index of the channel that supplied out_data
out_valid  output  1  output valid
out_ready  input  1  downstream ready

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, out_src=0.
  - RR pointer = NUM_IN-1, so channel 0 has first priority.
  - in_ready all 0 while reset is high.
- Stage load condition: load = !flush && (!out_valid || out_ready).
- Channel choice (combinational), "chosen":
  - MODE 0: chosen = sel.
  - MODE 0, sel >= NUM_IN: no channel is chosen and no input is accepted.
  - MODE 1: first i with in_valid[i]=1, scanning from ptr+1 upward with wrap modulo NUM_IN. If none is valid, nothing is chosen.
- in_ready[i] = load && (i == chosen). In MODE 1, in_ready[i] is additionally gated by in_valid[i].
- Transfer on input i: in_valid[i] && in_ready[i] at a clock edge. On the next edge: out_data = channel i data, out_src = i, out_valid = 1.
- Output consumption: out_valid && out_ready with no new transfer -> out_valid=0 next cycle; out_data and out_src hold their values.
- Stall: out_valid && !out_ready -> out_data, out_src and out_valid hold; all in_ready are 0.
- Simultaneous consume and transfer: the new word is loaded, giving full throughput of one word per cycle.
- flush=1 -> out_valid=0 next cycle and all in_ready=0 that cycle. Flush takes priority over transfer. The RR pointer is unchanged.
- RR pointer update: ptr = granted index, only on a transfer. With no transfer the pointer holds.
- Latency: exactly 1 cycle from input transfer to out_valid.
- out_data is never X after reset.

Optional Feature:
Macro PIPE_MUX_N_SKID_EN.
- Defined:
  - Adds a one-entry skid register, giving two stages of storage.
  - load = !flush && !skid_full. in_ready no longer depends combinationally on out_ready.
  - A transfer while out_valid && !out_ready writes the skid register.
  - When out_ready frees the output, the skid entry moves to the output on the next edge, preserving order.
  - flush clears both the output stage and the skid entry.
  - Latency remains 1 cycle when unstalled.
- Undefined:
  - Behaviour exactly as above: single stage, with a combinational path from out_ready to in_ready.

Test Plan:
- Reset mid-stream: assert reset while out_valid=1 and out_data=0xDEADBEEF -> out_valid, out_data and out_src go to 0 immediately, without waiting for a clock edge.
- MODE 0, NUM_IN=4: sel=2, in_valid=4'b0100, in_data ch2=0x12345678, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x12345678, out_src=2, out_valid=1.
- MODE 0 stall: out_valid=1, out_ready=0 for 3 cycles while ch1 is valid -> in_ready=0 throughout and out_data holds. Release out_ready -> ch1 data appears on the next edge, with no gap or duplicate.
- MODE 1 fairness: all 4 channels continuously valid with data 0xA0..0xA3, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one word per cycle.
- Flush priority: flush=1 in the same cycle as a ch3 transfer attempt -> in_ready=0, out_valid=0 next cycle, and the RR pointer is unchanged (ch3 is still next after a grant to ch2).
- SKID_EN: out_ready toggles 1,0,1,0 with ch0 continuously valid supplying 1,2,3,4 -> output order 1,2,3,4 with no loss, and in_ready never depends on same-cycle out_ready.
